// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the two requesters (m0 fetch, m1 load/store), the arbiter and the sdram controller.
// The master modport is the arbiter's view; slave is the requester/sdram side.
interface sdram_arbiter_if;
  localparam int unsigned ADDR_W = 33;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  logic              m0_req;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [SIZE_W-1:0] m0_size;
  logic              m0_ack;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [SIZE_W-1:0] m1_size;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic              sd_rw_req;
  logic              sd_rw;
  logic [ADDR_W-1:0] sd_address;
  logic [DATA_W-1:0] sd_write_data;
  logic [SIZE_W-1:0] sd_size;
  logic [DATA_W-1:0] sd_read_data;
  logic              sd_data_valid;

  modport master (
    input  m0_req, m0_rw, m0_addr, m0_wdata, m0_size,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_rw, m1_addr, m1_wdata, m1_size,
    output m1_ack, m1_err, m1_rdata,
    output sd_rw_req, sd_rw, sd_address, sd_write_data, sd_size,
    input  sd_read_data, sd_data_valid
  );

  modport slave (
    output m0_req, m0_rw, m0_addr, m0_wdata, m0_size,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_rw, m1_addr, m1_wdata, m1_size,
    input  m1_ack, m1_err, m1_rdata,
    input  sd_rw_req, sd_rw, sd_address, sd_write_data, sd_size,
    output sd_read_data, sd_data_valid
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer sharing the sdram controller's single rw_req port.
// Default: fixed m1>m0 priority. Define SDRAM_ARB_RR_EN for round-robin on simultaneous requests.
module sdram_arbiter #(
  parameter logic [32:0] SDRAM_BASE = 33'h2FFFF,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic            clk,
  input  logic            reset,
  sdram_arbiter_if.master bus,
  output logic            busy
);
  localparam int unsigned ADDR_W = 33;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE, S_HOLDOFF} state_t;

  state_t            state_q, state_d;
  logic              winner_q, winner_d;  // 0 = m0, 1 = m1
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sd_rw_req_q, sd_rw_req_d;
  logic              sd_rw_q, sd_rw_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [DATA_W-1:0] sd_wdata_q, sd_wdata_d;
  logic [SIZE_W-1:0] sd_size_q, sd_size_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              busy_d;
  logic              pick;
  logic              fin;
  logic              fin_err;
  logic [ADDR_W-1:0] req_addr;
`ifdef SDRAM_ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    sd_rw_req_d = sd_rw_req_q;
    sd_rw_d     = sd_rw_q;
    sd_addr_d   = sd_addr_q;
    sd_wdata_d  = sd_wdata_q;
    sd_size_d   = sd_size_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    req_addr    = '0;
`ifdef SDRAM_ARB_RR_EN
    last_grant_d = last_grant_q;
    pick         = bus.m1_req && (!bus.m0_req || !last_grant_q);
`else
    pick         = bus.m1_req;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          winner_d   = pick;
          req_addr   = pick ? bus.m1_addr  : bus.m0_addr;
          sd_rw_d    = pick ? bus.m1_rw    : bus.m0_rw;
          sd_wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
          sd_size_d  = pick ? bus.m1_size  : bus.m0_size;
          sd_addr_d  = req_addr;
          // Out-of-window requests never reach the sdram.
          if ((req_addr < SDRAM_BASE) || req_addr[31]) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d     = S_GRANT;
            err_d       = 1'b0;
            sd_rw_req_d = 1'b1;
          end
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_WAIT;
`ifdef SDRAM_ARB_RR_EN
        last_grant_d = winner_q;
`endif
      end
      S_WAIT: begin
        if (bus.sd_data_valid) begin
          sd_rw_req_d = 1'b0;
          state_d     = S_DONE;
          err_d       = 1'b0;
          fin         = 1'b1;
          if (!sd_rw_q) begin
            if (winner_q) m1_rdata_d = bus.sd_read_data;
            else          m0_rdata_d = bus.sd_read_data;
          end
        end else if (cnt_q >= (TIMEOUT - 16'd1)) begin
          sd_rw_req_d = 1'b0;
          state_d     = S_DONE;
          err_d       = 1'b1;
          fin         = 1'b1;
          fin_err     = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_HOLDOFF;
`ifdef SDRAM_ARB_RR_EN
        if (err_q) last_grant_d = winner_q;
`endif
      end
      S_HOLDOFF: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (fin) begin
      m0_ack_d = !winner_d;
      m1_ack_d = winner_d;
      m0_err_d = fin_err && !winner_d;
      m1_err_d = fin_err && winner_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      winner_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      sd_rw_req_q <= 1'b0;
      sd_rw_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_wdata_q  <= '0;
      sd_size_q   <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy        <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      sd_rw_req_q <= sd_rw_req_d;
      sd_rw_q     <= sd_rw_d;
      sd_addr_q   <= sd_addr_d;
      sd_wdata_q  <= sd_wdata_d;
      sd_size_q   <= sd_size_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      busy        <= busy_d;
`ifdef SDRAM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.sd_rw_req     = sd_rw_req_q;
  assign bus.sd_rw         = sd_rw_q;
  assign bus.sd_address    = sd_addr_q;
  assign bus.sd_write_data = sd_wdata_q;
  assign bus.sd_size       = sd_size_q;
  assign bus.m0_ack        = m0_ack_q;
  assign bus.m1_ack        = m1_ack_q;
  assign bus.m0_err        = m0_err_q;
  assign bus.m1_err        = m1_err_q;
  assign bus.m0_rdata      = m0_rdata_q;
  assign bus.m1_rdata      = m1_rdata_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requests push expected acks, a negedge monitor pops and checks.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  sdram_arbiter_if bus();

  sdram_arbiter #(.SDRAM_BASE(33'h2FFFF), .TIMEOUT(16'd16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_rd [2];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          dv_cyc = 0;

  // sdram model: data_valid pulses 6 cycles after rw_req rises, when enabled.
  logic        respond = 1'b1;
  logic        stray_dv = 1'b0;
  logic        model_dv = 1'b0;
  logic [31:0] rd_word = 32'h0;
  int          mcnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.sd_rw_req) begin
      mcnt     <= 0;
      model_dv <= 1'b0;
    end else begin
      mcnt     <= mcnt + 1;
      model_dv <= respond && (mcnt == 5);
    end
  end

  assign bus.sd_data_valid = model_dv | stray_dv;
  assign bus.sd_read_data  = rd_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic port, input logic err, input logic is_read,
                                   input logic [31:0] data);
    exp_t e;
    if (!err && is_read) exp_rd[port] = data;
    e.port  = port;
    e.err   = err;
    e.rdata = exp_rd[port];
    exp_q.push_back(e);
  endfunction

  // Monitor: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (bus.sd_data_valid) dv_cyc = cyc;
    if ((reset === 1'b1) && (bus.m0_ack || bus.m1_ack)) begin
      check("ack_onehot", 64'(bus.m0_ack & bus.m1_ack), 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none", bus.m0_ack, bus.m1_ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 64'(bus.m1_ack), 64'(e.port));
        check("ack_err", 64'(e.port ? bus.m1_err : bus.m0_err), 64'(e.err));
        check("ack_rdata", 64'(e.port ? bus.m1_rdata : bus.m0_rdata), 64'(e.rdata));
        if (!e.err) check("ack_after_dv", 64'(cyc), 64'(dv_cyc + 1));
      end
    end
  end

  task automatic drive(input logic port, input logic rw, input logic [32:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz);
    if (port) begin
      bus.m1_req = 1'b1; bus.m1_rw = rw; bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_size = sz;
    end else begin
      bus.m0_req = 1'b1; bus.m0_rw = rw; bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_size = sz;
    end
  endtask

  // Counts negedges until the given port acks; returns -1 if the bound expires.
  task automatic wait_ack(input logic port, input int limit, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (port ? bus.m1_ack : bus.m0_ack) return;
      if (n >= limit) begin
        tests++;
        fails++;
        $display("FAIL ack_timeout: got no ack on m%0d after %0d cycles expected an ack", port, n);
        n = -1;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int acks;
    reset = 1'b0;
    bus.m0_req = 1'b0; bus.m0_rw = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_size = '0;
    bus.m1_req = 1'b0; bus.m1_rw = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_size = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_sd_rw_req", 64'(bus.sd_rw_req), 64'd0);
    check("rst_sd_address", 64'(bus.sd_address), 64'd0);
    check("rst_sd_write_data", 64'(bus.sd_write_data), 64'd0);
    check("rst_sd_size", 64'(bus.sd_size), 64'd0);
    check("rst_acks", 64'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: m0 read alone
    rd_word = 32'h11223344;
    push_exp(1'b0, 1'b0, 1'b1, 32'h11223344);
    drive(1'b0, 1'b0, 33'h30000, 32'h0, 2'd2);
    @(negedge clk);
    check("t1_rw_req_next_cycle", 64'(bus.sd_rw_req), 64'd1);
    check("t1_sd_address", 64'(bus.sd_address), 64'h30000);
    check("t1_busy", 64'(busy), 64'd1);
    wait_ack(1'b0, 30, n);
    bus.m0_req = 1'b0;
    check("t1_ack_latency", 64'(n + 1), 64'd8);
    repeat (3) @(negedge clk);
    check("t1_rdata_held", 64'(bus.m0_rdata), 64'h11223344);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: simultaneous requests, m1 write first
    rd_word = 32'hAABBCCDD;
    push_exp(1'b1, 1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b0, 1'b1, 32'hAABBCCDD);
    drive(1'b0, 1'b0, 33'h30004, 32'h0, 2'd2);
    drive(1'b1, 1'b1, 33'h40000, 32'hDEADBEEF, 2'd2);
    @(negedge clk);
    check("t2_sd_rw", 64'(bus.sd_rw), 64'd1);
    check("t2_sd_write_data", 64'(bus.sd_write_data), 64'hDEADBEEF);
    check("t2_sd_address", 64'(bus.sd_address), 64'h40000);
    check("t2_sd_size", 64'(bus.sd_size), 64'd2);
    wait_ack(1'b1, 30, n);
    bus.m1_req = 1'b0;
    wait_ack(1'b0, 30, n);
    bus.m0_req = 1'b0;
    check("t2_m0_after_holdoff", 64'(n), 64'd10);
    repeat (3) @(negedge clk);

    // 3: window misses and the lowest legal address
    push_exp(1'b1, 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 33'h1000, 32'h0, 2'd2);
    @(negedge clk);
    check("t3_low_ack", 64'(bus.m1_ack), 64'd1);
    check("t3_low_no_rw_req", 64'(bus.sd_rw_req), 64'd0);
    bus.m1_req = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(1'b0, 1'b1, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 33'h0_8003_0000, 32'h0, 2'd2);
    @(negedge clk);
    check("t3_bit31_ack", 64'(bus.m0_ack), 64'd1);
    check("t3_bit31_no_rw_req", 64'(bus.sd_rw_req), 64'd0);
    bus.m0_req = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(1'b0, 1'b1, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 33'h2FFFE, 32'h0, 2'd0);
    @(negedge clk);
    check("t3_below_base_ack", 64'(bus.m0_ack), 64'd1);
    bus.m0_req = 1'b0;
    repeat (3) @(negedge clk);
    rd_word = 32'h0BADF00D;
    push_exp(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    drive(1'b0, 1'b0, 33'h2FFFF, 32'h0, 2'd0);
    wait_ack(1'b0, 30, n);
    bus.m0_req = 1'b0;
    check("t3_base_latency", 64'(n), 64'd8);
    repeat (3) @(negedge clk);

    // 4: sdram never answers -> timeout, then a stray strobe
    respond = 1'b0;
    push_exp(1'b0, 1'b1, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 33'h30008, 32'h0, 2'd2);
    wait_ack(1'b0, 40, n);
    bus.m0_req = 1'b0;
    check("t4_timeout_latency", 64'(n), 64'd18);
    check("t4_rw_req_dropped", 64'(bus.sd_rw_req), 64'd0);
    repeat (2) @(negedge clk);
    stray_dv = 1'b1;
    @(negedge clk);
    stray_dv = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_stray_idle", 64'(busy), 64'd0);
    respond = 1'b1;

    // 5: reset during WAIT
    rd_word = 32'h99999999;
    drive(1'b0, 1'b0, 33'h30000, 32'h0, 2'd2);
    repeat (3) @(negedge clk);
    check("t5_in_wait", 64'(bus.sd_rw_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_rw_req", 64'(bus.sd_rw_req), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    bus.m0_req = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("t5_rdata_cleared", 64'(bus.m0_rdata), 64'd0);
    @(negedge clk);
    rd_word = 32'h55667788;
    push_exp(1'b0, 1'b0, 1'b1, 32'h55667788);
    drive(1'b0, 1'b0, 33'h3000C, 32'h0, 2'd2);
    wait_ack(1'b0, 30, n);
    bus.m0_req = 1'b0;
    check("t5_after_reset_latency", 64'(n), 64'd8);
    repeat (3) @(negedge clk);

    // 6: both ports request continuously for four transfers
    pulse_reset();
    @(negedge clk);
`ifdef SDRAM_ARB_RR_EN
    push_exp(1'b0, 1'b0, 1'b0, 32'h0);
    push_exp(1'b1, 1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b0, 1'b0, 32'h0);
    push_exp(1'b1, 1'b0, 1'b0, 32'h0);
`else
    repeat (4) push_exp(1'b1, 1'b0, 1'b0, 32'h0);
`endif
    drive(1'b0, 1'b1, 33'h30010, 32'h01010101, 2'd2);
    drive(1'b1, 1'b1, 33'h30020, 32'h02020202, 2'd2);
    acks = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) acks++;
      if (acks == 4) break;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check("t6_ack_count", 64'(acks), 64'd4);
    repeat (4) @(negedge clk);
    check("t6_idle", 64'(busy), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
